// File: rtl/mips_pkg.sv
// Shared constants for the MIPS32 decode/execute datapath: immediate-extension
// mode encodings, operand widths and a small sign-extension helper.
package mips_pkg;

  localparam int IMM_W  = 16;
  localparam int DATA_W = 32;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_BR   = 2'b11;

  // Replicates the immediate's top bit across the upper half of the word.
  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage : mips_pkg

// File: rtl/ext_core.sv
// Combinational immediate extender: widens the 16-bit immediate to a 32-bit
// operand according to the selected extension mode.
module ext_core
  import mips_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        EOp,
  output logic [DATA_W-1:0] ext
);

  logic [DATA_W-1:0] w_sext;

  assign w_sext = sext_imm(imm);

  // NOTE: every encoding has an arm and the default assigns too, so ext is
  // driven on all paths and no latch is inferred; an X select yields all-X.
  always_comb begin
    case (EOp)
      EXT_ZERO: ext = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SIGN: ext = w_sext;
      EXT_LUI:  ext = {imm, {(DATA_W-IMM_W){1'b0}}};
      // The bits shifted out are sign copies, so the branch offset is exact.
      EXT_BR:   ext = {w_sext[DATA_W-3:0], 2'b00};
      default:  ext = {DATA_W{1'bx}};
    endcase
  end

endmodule : ext_core

// File: rtl/ext_unit.sv
// Immediate extender with a combinational result and a one-cycle registered
// copy qualified by out_valid for the pipelined datapath.
module ext_unit
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        EOp,
  input  logic              in_valid,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] ext_q,
  output logic              out_valid
);

  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] r_ext_q;
  logic              r_out_valid;

  ext_core u_ext_core (
    .imm (imm),
    .EOp (EOp),
    .ext (w_ext)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset is checked first so it overrides a same-cycle in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext_q     <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_ext_q     <= w_ext;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign ext       = w_ext;
  assign ext_q     = r_ext_q;
  assign out_valid = r_out_valid;

endmodule : ext_unit

// File: tb/tb_ext_unit.sv
// Directed bench for ext_unit: checks the combinational extender against
// reference constants and the registered path through an expected-result queue.
module tb_ext_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imm;
  logic [1:0]  EOp;
  logic        in_valid;
  logic [31:0] ext;
  logic [31:0] ext_q;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb_q[$];
  logic [31:0] last_q = 32'h0;

  always #5 clk = ~clk;

  ext_unit dut (
    .clk       (clk),
    .reset     (reset),
    .imm       (imm),
    .EOp       (EOp),
    .in_valid  (in_valid),
    .ext       (ext),
    .ext_q     (ext_q),
    .out_valid (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, check ext combinationally,
  // then check the registered outputs shortly after the following rising edge.
  task automatic step(input string tag, input logic rst, input logic vld,
                      input logic [15:0] i_imm, input logic [1:0] i_eop,
                      input logic [31:0] exp_ext);
    logic        exp_valid;
    logic [31:0] exp_q;
    @(negedge clk);
    reset    = rst;
    in_valid = vld;
    imm      = i_imm;
    EOp      = i_eop;
    #1;
    if (!rst) check({tag, "_ext"}, ext, exp_ext);
    if (vld && !rst) sb_q.push_back(exp_ext);
    exp_valid = vld && !rst;
    @(posedge clk);
    #1;
    check({tag, "_out_valid"}, {31'b0, out_valid}, {31'b0, exp_valid});
    if (rst) begin
      last_q = 32'h0;
    end else if (exp_valid) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_underflow"}, 32'd0, 32'd1);
      end else begin
        last_q = sb_q.pop_front();
      end
    end
    exp_q = last_q;
    check({tag, "_ext_q"}, ext_q, exp_q);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    imm      = 16'h0;
    EOp      = 2'b00;

    // T4 (first half): two reset cycles clear the register stage
    step("t4_rst0", 1'b1, 1'b0, 16'h0000, 2'b00, 32'h0);
    step("t4_rst1", 1'b1, 1'b0, 16'h0000, 2'b00, 32'h0);

    // T1: negative immediate, all modes
    step("t1_zero", 1'b0, 1'b0, 16'hfabc, 2'b00, 32'h0000fabc);
    step("t1_sign", 1'b0, 1'b0, 16'hfabc, 2'b01, 32'hfffffabc);
    step("t1_lui",  1'b0, 1'b0, 16'hfabc, 2'b10, 32'hfabc0000);
    step("t1_br",   1'b0, 1'b0, 16'hfabc, 2'b11, 32'hffffeaf0);

    // T2: positive immediate, all modes
    step("t2_zero", 1'b0, 1'b0, 16'h7abc, 2'b00, 32'h00007abc);
    step("t2_sign", 1'b0, 1'b0, 16'h7abc, 2'b01, 32'h00007abc);
    step("t2_lui",  1'b0, 1'b0, 16'h7abc, 2'b10, 32'h7abc0000);
    step("t2_br",   1'b0, 1'b0, 16'h7abc, 2'b11, 32'h0001eaf0);

    // T3: boundaries
    step("t3_min_sign", 1'b0, 1'b0, 16'h8000, 2'b01, 32'hffff8000);
    step("t3_min_br",   1'b0, 1'b0, 16'h8000, 2'b11, 32'hfffe0000);
    step("t3_m1_br",    1'b0, 1'b0, 16'hffff, 2'b11, 32'hfffffffc);
    for (int m = 0; m < 4; m++)
      step("t3_zero_imm", 1'b0, 1'b0, 16'h0000, m[1:0], 32'h0);

    // T4 (second half): first valid input after reset
    step("t4_valid", 1'b0, 1'b1, 16'hfabc, 2'b01, 32'hfffffabc);

    // T5: back-to-back valid inputs, then an idle cycle holds ext_q
    step("t5_zero", 1'b0, 1'b1, 16'h1234, 2'b00, 32'h00001234);
    step("t5_lui",  1'b0, 1'b1, 16'hbeef, 2'b10, 32'hbeef0000);
    step("t5_br",   1'b0, 1'b1, 16'h8001, 2'b11, 32'hfffe0004);
    step("t5_idle", 1'b0, 1'b0, 16'h5555, 2'b01, 32'h00005555);

    // T6: reset wins over a simultaneous valid, then the stream resumes
    step("t6_rst_vld", 1'b1, 1'b1, 16'hfabc, 2'b10, 32'h0);
    step("t6_resume",  1'b0, 1'b1, 16'h7abc, 2'b11, 32'h0001eaf0);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_ext_unit
